wb_cmd_master: RTL and testbench



---
 rtl/wb_cmd_master.sv | 253 +++++++++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns a byte-stream command protocol into single-beat
// Wishbone B4 pipelined accesses and returns status/read data as bytes.
// Commands are little-endian: 0x01 A0..A3 D0..D3 (write), 0x02 A0..A3 (read).
// Responses: 0x06 write ok, 4 data bytes for a read, 0x15 bus error/timeout,
// 0x3F unknown opcode.
module wb_cmd_master #(
  parameter int TIMEOUT = 1024,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [3:0]        wb_sel,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack,
  input  logic              wb_err,
  input  logic              wb_stall,
  output logic              busy
);

  // The timeout counter only has to reach TIMEOUT-1.
  localparam int            TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam logic [7:0] RSP_BAD  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP,
    S_RDATA
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    cnt_reg, cnt_next;
  logic [1:0]    cnt_plus;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          we_reg, we_next;
  logic          cyc_reg, cyc_next;
  logic          stb_reg, stb_next;
  logic [3:0]    sel_reg, sel_next;
  logic [31:0]   adr_reg, adr_next;
  logic [31:0]   dat_o_reg, dat_o_next;
  logic [31:0]   rdat_reg, rdat_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          tx_valid_reg, tx_valid_next;
  logic          rx_ready_reg, rx_ready_next;

  logic          rx_fire;
  logic          tx_fire;

  assign rx_fire = rx_valid && rx_ready_reg;
  assign tx_fire = tx_valid_reg && tx_ready;

  // Next-state and next-output logic; every register holds unless a case below moves it.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    tcnt_next     = tcnt_reg;
    we_next       = we_reg;
    cyc_next      = cyc_reg;
    stb_next      = stb_reg;
    sel_next      = sel_reg;
    adr_next      = adr_reg;
    dat_o_next    = dat_o_reg;
    rdat_next     = rdat_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    cnt_plus      = cnt_reg + 2'd1;

    case (state_reg)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            we_next    = (rx_data == OP_WRITE);
            cnt_next   = 2'd0;
            state_next = S_ADDR;
          end else begin
            tx_data_next  = RSP_BAD;
            tx_valid_next = 1'b1;
            state_next    = S_RESP;
          end
        end
      end

      S_ADDR: begin
        if (rx_fire) begin
          adr_next[{cnt_reg, 3'b000} +: 8] = rx_data;
          cnt_next = cnt_plus;
          if (cnt_reg == 2'd3) begin
            if (we_reg) begin
              state_next = S_WDATA;
            end else begin
              // Reads start the bus cycle straight after the last address byte.
              cyc_next   = 1'b1;
              stb_next   = 1'b1;
              sel_next   = 4'hF;
              tcnt_next  = '0;
              state_next = S_BUS;
            end
          end
        end
      end

      S_WDATA: begin
        if (rx_fire) begin
          dat_o_next[{cnt_reg, 3'b000} +: 8] = rx_data;
          cnt_next = cnt_plus;
          if (cnt_reg == 2'd3) begin
            cyc_next   = 1'b1;
            stb_next   = 1'b1;
            sel_next   = 4'hF;
            tcnt_next  = '0;
            state_next = S_BUS;
          end
        end
      end

      S_BUS: begin
        tcnt_next = tcnt_reg + TW'(1);
        // The request is taken on the first edge the slave is not stalling.
        if (stb_reg && !wb_stall) begin
          stb_next = 1'b0;
        end
        // err is checked first so it wins over a simultaneous ack.
        if (wb_err) begin
          cyc_next      = 1'b0;
          stb_next      = 1'b0;
          tx_data_next  = RSP_NAK;
          tx_valid_next = 1'b1;
          state_next    = S_RESP;
        end else if (wb_ack) begin
          cyc_next      = 1'b0;
          stb_next      = 1'b0;
          tx_valid_next = 1'b1;
          if (we_reg) begin
            tx_data_next = RSP_ACK;
            state_next   = S_RESP;
          end else begin
            rdat_next    = wb_dat_i;
            cnt_next     = 2'd0;
            tx_data_next = wb_dat_i[7:0];
            state_next   = S_RDATA;
          end
        end else if (tcnt_reg == TLAST) begin
          // Abandon the cycle; a late ack lands in IDLE where it is ignored.
          cyc_next      = 1'b0;
          stb_next      = 1'b0;
          tx_data_next  = RSP_NAK;
          tx_valid_next = 1'b1;
          state_next    = S_RESP;
        end
      end

      S_RESP: begin
        if (tx_fire) begin
          tx_valid_next = 1'b0;
          state_next    = S_IDLE;
        end
      end

      S_RDATA: begin
        if (tx_fire) begin
          if (cnt_reg == 2'd3) begin
            cnt_next      = 2'd0;
            tx_valid_next = 1'b0;
            state_next    = S_IDLE;
          end else begin
            cnt_next     = cnt_plus;
            tx_data_next = rdat_reg[{cnt_plus, 3'b000} +: 8];
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // The receiver is only open while a command is being collected.
    rx_ready_next = (state_next == S_IDLE) || (state_next == S_ADDR) ||
                    (state_next == S_WDATA);
  end

  // State and output registers; reset also discards any partial command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 2'd0;
      tcnt_reg     <= '0;
      we_reg       <= 1'b0;
      cyc_reg      <= 1'b0;
      stb_reg      <= 1'b0;
      sel_reg      <= 4'h0;
      adr_reg      <= 32'h0;
      dat_o_reg    <= 32'h0;
      rdat_reg     <= 32'h0;
      tx_data_reg  <= 8'h0;
      tx_valid_reg <= 1'b0;
      rx_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      tcnt_reg     <= tcnt_next;
      we_reg       <= we_next;
      cyc_reg      <= cyc_next;
      stb_reg      <= stb_next;
      sel_reg      <= sel_next;
      adr_reg      <= adr_next;
      dat_o_reg    <= dat_o_next;
      rdat_reg     <= rdat_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      rx_ready_reg <= rx_ready_next;
    end
  end

  // The command always carries 32 address bits; fit them to the bus width.
  generate
    if (ADDR_W <= 32) begin : g_adr_narrow
      assign wb_adr = adr_reg[ADDR_W-1:0];
    end else begin : g_adr_wide
      assign wb_adr = {{(ADDR_W-32){1'b0}}, adr_reg};
    end
  endgenerate

  assign wb_cyc   = cyc_reg;
  assign wb_stb   = stb_reg;
  assign wb_we    = we_reg;
  assign wb_sel   = sel_reg;
  assign wb_dat_o = dat_o_reg;
  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign rx_ready = rx_ready_reg;
  assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: randomized commands, a reference model computing the
// expected WB request and response bytes, and a monitor/slave process that
// compares what the DUT produces against the scoreboard queues.
module tb_wb_cmd_master;
  localparam int TIMEOUT = 16;
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;
  logic        busy;

  wb_cmd_master #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall), .busy(busy)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    int          mode;
    int          stall;
    int          dly;
    logic [31:0] rdata;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [7:0] tx_q[$];
  bus_exp_t   mon_cur;
  int total = 0;
  int bad   = 0;
  int tx_mode = 0;   // 0 always ready, 1 toggling, 2 random, 3 held low
  int late_req = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want test done");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, expv);
    end
  endtask

  // Reference model: the response bytes a command must produce.
  task automatic ref_expect(input logic [7:0] op, input int mode, input logic [31:0] rdata);
    if (op != 8'h01 && op != 8'h02) begin
      tx_q.push_back(8'h3F);
    end else if (mode != M_ACK) begin
      tx_q.push_back(8'h15);
    end else if (op == 8'h01) begin
      tx_q.push_back(8'h06);
    end else begin
      for (int i = 0; i < 4; i++) tx_q.push_back(8'(rdata >> (8 * i)));
    end
  endtask

  // Slave model, tx_ready driver and checker, all at the falling edge.
  initial begin : monitor
    int  bt;
    int  sc;
    int  seq_t;
    int  late_done;
    int  exp_len;
    logic hit;
    bt = 0; sc = 0; seq_t = 0; late_done = 0;
    mon_cur = '{adr: 0, we: 0, dat: 0, mode: M_ACK, stall: 0, dly: 0, rdata: 0};
    wb_ack = 0; wb_err = 0; wb_stall = 0; wb_dat_i = 0; tx_ready = 0;
    forever begin
      @(negedge clk);
      seq_t++;
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((seq_t % 2) == 0);
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
      if (rst) begin
        bt = 0; sc = 0; wb_ack = 0; wb_err = 0; wb_stall = 0;
        continue;
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: got 0x%02h want no byte", tx_data);
        end else begin
          chk("tx_byte", tx_data, tx_q.pop_front());
        end
      end
      if (wb_cyc || tx_valid) chk("rx_ready_closed", rx_ready, 0);
      if (wb_cyc) begin
        if (bt == 0) begin
          if (bus_q.size() == 0) begin
            total++; bad++;
            $display("FAIL wb_unexpected: got cycle at adr 0x%08h want none", wb_adr);
            mon_cur = '{adr: 0, we: 0, dat: 0, mode: M_ACK, stall: 0, dly: 0, rdata: 0};
          end else begin
            mon_cur = bus_q.pop_front();
            chk("wb_adr", wb_adr, mon_cur.adr);
            chk("wb_we", wb_we, mon_cur.we);
            chk("wb_sel", wb_sel, 4'hF);
            if (mon_cur.we) chk("wb_dat_o", wb_dat_o, mon_cur.dat);
          end
        end
        bt++;
        if (wb_stb) sc++;
        wb_stall = (bt <= mon_cur.stall);
        hit      = (mon_cur.mode != M_NONE) && (bt == mon_cur.stall + 1 + mon_cur.dly);
        wb_ack   = hit && (mon_cur.mode == M_ACK || mon_cur.mode == M_BOTH);
        wb_err   = hit && (mon_cur.mode == M_ERR || mon_cur.mode == M_BOTH);
        wb_dat_i = hit ? mon_cur.rdata : $urandom;
      end else begin
        if (bt > 0) begin
          exp_len = (mon_cur.mode == M_NONE) ? TIMEOUT : mon_cur.stall + 1 + mon_cur.dly;
          chk("cyc_len", bt, exp_len);
          chk("stb_len", sc, mon_cur.stall + 1);
          bt = 0; sc = 0;
        end
        wb_stall = 0;
        wb_err   = 0;
        wb_dat_i = $urandom;
        if (late_req != late_done) begin
          wb_ack = 1'b1;
          late_done++;
        end else begin
          wb_ack = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cyc"}, wb_cyc, 0);
    chk({tag, "_stb"}, wb_stb, 0);
    chk({tag, "_we"}, wb_we, 0);
    chk({tag, "_sel"}, wb_sel, 0);
    chk({tag, "_adr"}, wb_adr, 0);
    chk({tag, "_dat_o"}, wb_dat_o, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      total++; bad++;
      $display("FAIL rx_accept: rx_ready got 0 want 1 within 200 cycles");
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_q.size() != 0 || bus_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("pending_items", tx_q.size() + bus_q.size(), 0);
    chk("busy_end", busy, 0);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat,
                         input int mode, input int stall, input int dly,
                         input logic [31:0] rdata, input int txm, input int gap);
    logic [7:0] bytes[$];
    bus_exp_t   e;
    tx_mode = txm;
    bytes.push_back(op);
    if (op == 8'h01 || op == 8'h02) begin
      for (int i = 0; i < 4; i++) bytes.push_back(8'(adr >> (8 * i)));
      if (op == 8'h01)
        for (int i = 0; i < 4; i++) bytes.push_back(8'(dat >> (8 * i)));
    end
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == bytes.size() - 1) begin
        ref_expect(op, mode, rdata);
        if (op == 8'h01 || op == 8'h02) begin
          e = '{adr: adr, we: (op == 8'h01), dat: dat, mode: mode,
                stall: stall, dly: dly, rdata: rdata};
          bus_q.push_back(e);
        end
      end
      if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
      send_byte(bytes[i]);
    end
    wait_idle();
    $display("txn op=%02h adr=%08h dat=%08h mode=%0d stall=%0d dly=%0d rdata=%08h",
             op, adr, dat, mode, stall, dly, rdata);
  endtask

  initial begin : stimulus
    int n;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Write with a one-cycle ack.
    run_cmd(8'h01, 32'h10, 32'hDEADBEEF, M_ACK, 0, 0, 32'h0, 0, 0);
    // Read with 3 stall cycles, ack 2 cycles after acceptance, toggling tx_ready.
    run_cmd(8'h02, 32'h10, 32'h0, M_ACK, 3, 2, 32'hDEADBEEF, 1, 0);
    // Simultaneous ack and err: err wins.
    run_cmd(8'h02, 32'h44, 32'h0, M_BOTH, 0, 1, 32'h12345678, 0, 0);
    // Plain error on a write.
    run_cmd(8'h01, 32'h80, 32'hCAFEF00D, M_ERR, 1, 0, 32'h0, 0, 0);

    // Timeout, then a late ack that must be ignored.
    run_cmd(8'h02, 32'h100, 32'h0, M_NONE, 0, 0, 32'h0, 0, 0);
    repeat (4) @(negedge clk);
    late_req++;
    repeat (4) @(negedge clk);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_cyc", wb_cyc, 0);
    chk("late_ack_tx_valid", tx_valid, 0);
    chk("late_ack_rx_ready", rx_ready, 1);

    // Unknown opcode with the response held off for 10 cycles.
    tx_mode = 3;
    ref_expect(8'h7A, M_ACK, 32'h0);
    send_byte(8'h7A);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_tx_valid", tx_valid, 1);
      chk("bp_tx_data", tx_data, 8'h3F);
      chk("bp_rx_ready", rx_ready, 0);
      @(negedge clk);
    end
    tx_mode = 0;
    wait_idle();
    run_cmd(8'h01, 32'h24, 32'h0BADCAFE, M_ACK, 0, 0, 32'h0, 0, 0);

    // Reset in the middle of a command leaves no stale address bytes.
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    run_cmd(8'h02, 32'h20, 32'h0, M_ACK, 0, 0, 32'hA5A55A5A, 0, 0);

    // Randomized commands.
    for (int t = 0; t < 30; t++) begin
      int r;
      int m;
      logic [7:0] op;
      r = $urandom_range(0, 9);
      if (r < 4) op = 8'h01;
      else if (r < 8) op = 8'h02;
      else begin
        op = 8'($urandom_range(3, 255));
      end
      m = $urandom_range(0, 5);
      run_cmd(op, $urandom, $urandom, (m < 3) ? M_ACK : m - 2,
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom,
              $urandom_range(0, 2), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
